ccg_bist_sequencer: RTL and testbench
=====================================

// Module: ccg_bist_sequencer
// PURPOSE
// - Self-test sequencer for one 14-in/22-out combinational benchmark netlist (x0..x13 -> f1..f22).
// - Drives the netlist inputs with exhaustive-count or LFSR vectors.
// - Compacts every 22-bit response into a MISR signature and compares it with an expected value.
// - Sits between the dataset harness (start/done handshake) and the combinational netlist instance.
// PARAMETERS
// - IN_W     14      netlist input width (dut_x)
// - OUT_W    22      netlist output width (dut_f)
// - SETTLE   1       cycles each vector is held before capture; legal range >=1
// - CNT_W    15      vector-count width; covers 2**IN_W
// PORTS
// - clk          in   1      single clock, rising edge
// - rst_n        in   1      asynchronous active-low reset
// - start        in   1      one-cycle request; accepted only in IDLE
// - abort        in   1      return to IDLE from any state; done not pulsed
// - mode         in   1      0 = binary count from 0, 1 = LFSR from seed
// - seed         in   IN_W   LFSR seed, sampled at start; 0 is replaced by 1
// - num_vectors  in   CNT_W  vectors to apply, sampled at start
// - exp_sig      in   OUT_W  expected signature, sampled at start
// - dut_x        out  IN_W   registered netlist inputs x0..x13 (bit i = x<i>)
// - dut_f        in   OUT_W  netlist outputs f1..f22 (bit i = f<i+1>)
// - busy         out  1      high in APPLY
// - done         out  1      one-cycle pulse in DONE
// - pass         out  1      signature==exp_sig; valid from done until next start
// - signature    out  OUT_W  MISR state; stable in IDLE
// - vec_count    out  CNT_W  vectors captured so far
// BEHAVIOUR
// - Reset: state=IDLE; dut_x, signature, vec_count = 0; busy, done, pass = 0.
// - States: IDLE, APPLY, DONE.
// - IDLE + start: latch mode/num_vectors/exp_sig; signature<=0; vec_count<=0; pass<=0.
//   - dut_x <= 0 (mode 0) or seed|(seed==0) (mode 1).
//   - Next state: APPLY, or DONE if num_vectors==0.
// - APPLY: settle counter runs 0..SETTLE-1; dut_x held constant.
// - Last settle cycle:
//   - MISR: sig <= {sig[OUT_W-2:0], sig[21]^sig[20]} ^ dut_f  (x^22+x^21+1).
//   - vec_count++.
//   - Advance vector: mode 0 dut_x+1, wraps at 2**IN_W.
//   - Mode 1 Fibonacci LFSR: dut_x <= {dut_x[12:0], dut_x[13]^dut_x[4]^dut_x[2]^dut_x[0]}.
//   - If vec_count+1==num_vectors -> DONE.
// - Vector duration: each vector holds exactly SETTLE cycles. Start-to-done latency = 1 + N*SETTLE cycles.
// - DONE: done=1 for one cycle; pass <= (signature==exp_sig); -> IDLE. dut_x keeps its last (advanced) value.
// - start outside IDLE: ignored.
// - abort: highest priority. In any state -> IDLE next cycle; busy=0; done=0; signature/vec_count frozen; pass=0.
// - abort and start in the same IDLE cycle: abort wins; the start is dropped.
// - num_vectors > 2**IN_W in mode 0: counter wraps and the vector sequence repeats.
// - Reset mid-operation: immediate return to reset values; no done pulse.
// STRUCTURE
// - Package ccg_bist_pkg:
//   - state_t enum {IDLE, APPLY, DONE}.
//   - IN_W/OUT_W defaults.
//   - LFSR tap mask 14'h2015 and MISR tap mask 22'h300000.
// - Sub-module ccg_misr (OUT_W, tap mask; clear, en, din -> sig) holds the compactor.
// - FSM, settle counter, vector generator and compare stay in the top.
// TESTING
// - Mode 0, N=4, SETTLE=1, dut_f tied 0:
//   - dut_x = 0,1,2,3 over cycles 1-4; done at cycle 5.
//   - signature = 0; pass=1 with exp_sig=0.
// - dut_f=22'h000001 constant, N=3: signature = 1 -> 3 -> 7; final 22'h000007.
//   - exp_sig=7 gives pass=1; exp_sig=6 gives pass=0.
// - Mode 1, seed=14'h0001, N=3: applied dut_x = 14'h0001, 14'h0003, 14'h0007. seed=0 gives the same sequence.
// - SETTLE=3, N=2: each vector held 3 cycles; busy high 6 cycles; done at cycle 7; vec_count=2.
// - abort in 2nd APPLY cycle of N=10: IDLE next cycle, no done, vec_count=1. A start issued while busy has no effect.
// - num_vectors=0: done one cycle after start, signature=0, busy never high.
// - rst_n low mid-APPLY: all outputs 0 asynchronously.

Source files
------------

// File: rtl/ccg_bist_pkg.sv
// Shared types and constants for the ccg BIST sequencer and its signature compactor.
// Tap masks encode x^14+x^5+x^3+x^1+1-style feedback (bits 13,4,2,0) and MISR x^22+x^21+1.
package ccg_bist_pkg;

   localparam int IN_W_DEF  = 14;
   localparam int OUT_W_DEF = 22;
   localparam int CNT_W_DEF = 15;

   localparam logic [13:0] LFSR_TAP = 14'h2015;
   localparam logic [21:0] MISR_TAP = 22'h300000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register: shift with parity feedback, then fold in the response word.
// One cycle per compaction step; clear has priority over en. sig_step is the would-be next value.
module ccg_misr
   import ccg_bist_pkg::*;
#(
   parameter int               OUT_W = OUT_W_DEF,
   parameter logic [OUT_W-1:0] TAP   = OUT_W'(MISR_TAP)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [OUT_W-1:0] din,
   output logic [OUT_W-1:0] sig,
   output logic [OUT_W-1:0] sig_step
);

   logic [OUT_W-1:0] sig_q;
   logic [OUT_W-1:0] sig_d;

   always_comb begin
      sig_step = {sig_q[OUT_W-2:0], ^(sig_q & TAP)} ^ din;
      sig_d    = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = sig_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/ccg_bist_sequencer.sv
// BIST sequencer: drives count/LFSR vectors into a combinational netlist, compacts responses, compares.
// Start-to-done latency 1 + N*SETTLE cycles; start is ignored unless IDLE, abort wins over everything.
module ccg_bist_sequencer
   import ccg_bist_pkg::*;
#(
   parameter int IN_W   = IN_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int SETTLE = 1,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic [IN_W-1:0]  seed,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic [OUT_W-1:0] exp_sig,
   output logic [IN_W-1:0]  dut_x,
   input  logic [OUT_W-1:0] dut_f,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [OUT_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count
);

   localparam int              SET_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IN_W-1:0] LFSR_MASK = IN_W'(LFSR_TAP);

   state_t           state_q,     state_d;
   logic             mode_q,      mode_d;
   logic [CNT_W-1:0] num_q,       num_d;
   logic [OUT_W-1:0] exp_q,       exp_d;
   logic [IN_W-1:0]  dut_x_q,     dut_x_d;
   logic [SET_W-1:0] set_cnt_q,   set_cnt_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             pass_q,      pass_d;

   logic             misr_clear;
   logic             misr_en;
   logic [OUT_W-1:0] sig_step;
   logic             last_settle;
   logic [IN_W-1:0]  vec_nxt;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      last_settle = (set_cnt_q == SET_W'(SETTLE - 1));
      vec_nxt     = mode_q ? {dut_x_q[IN_W-2:0], ^(dut_x_q & LFSR_MASK)}
                           : dut_x_q + IN_W'(1);
      cnt_inc     = vec_count_q + CNT_W'(1);

      state_d     = state_q;
      mode_d      = mode_q;
      num_d       = num_q;
      exp_d       = exp_q;
      dut_x_d     = dut_x_q;
      set_cnt_d   = set_cnt_q;
      vec_count_d = vec_count_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      misr_clear  = 1'b0;
      misr_en     = 1'b0;

      // Abort freezes signature and count so the partial result stays observable.
      if (abort) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_d      = mode;
                  num_d       = num_vectors;
                  exp_d       = exp_sig;
                  misr_clear  = 1'b1;
                  vec_count_d = '0;
                  set_cnt_d   = '0;
                  pass_d      = 1'b0;
                  dut_x_d     = mode ? ((seed == '0) ? IN_W'(1) : seed) : '0;
                  if (num_vectors == '0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     pass_d  = (exp_sig == '0);
                  end else begin
                     state_d = APPLY;
                     busy_d  = 1'b1;
                  end
               end
            end
            APPLY: begin
               if (last_settle) begin
                  misr_en     = 1'b1;
                  vec_count_d = cnt_inc;
                  dut_x_d     = vec_nxt;
                  set_cnt_d   = '0;
                  // pass is registered alongside done, so compare the post-capture signature.
                  if (cnt_inc == num_q) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (sig_step == exp_q);
                  end
               end else begin
                  set_cnt_d = set_cnt_q + SET_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         num_q       <= '0;
         exp_q       <= '0;
         dut_x_q     <= '0;
         set_cnt_q   <= '0;
         vec_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         num_q       <= num_d;
         exp_q       <= exp_d;
         dut_x_q     <= dut_x_d;
         set_cnt_q   <= set_cnt_d;
         vec_count_q <= vec_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   ccg_misr #(
      .OUT_W (OUT_W),
      .TAP   (OUT_W'(MISR_TAP))
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (misr_clear),
      .en       (misr_en),
      .din      (dut_f),
      .sig      (signature),
      .sig_step (sig_step)
   );

   assign dut_x     = dut_x_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign vec_count = vec_count_q;

endmodule

// File: tb/tb_ccg_bist_sequencer.sv
// Bench for ccg_bist_sequencer: SETTLE=1 and SETTLE=3 instances, netlist modelled as a hash of dut_x.
module tb_ccg_bist_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, start3, abort, mode;
   logic [13:0] seed;
   logic [14:0] num_vectors;
   logic [21:0] exp_sig;

   logic [13:0] x1, x3;
   logic [21:0] f1, f3, sig1, sig3;
   logic [14:0] cnt1, cnt3;
   logic        busy1, busy3, done1, done3, pass1, pass3;

   int          sel;
   int          fsel;
   logic [21:0] fconst;
   int          n_pass, n_total;

   logic [13:0] o_x;
   logic [21:0] o_sig;
   logic [14:0] o_cnt;
   logic        o_busy, o_done, o_pass;

   logic [13:0] ob_x[$];
   logic [21:0] ob_sig[$];
   logic [14:0] ob_cnt[$];
   logic        ob_busy[$], ob_done[$], ob_pass[$];
   int          done_cyc;

   logic [13:0] m_vec[$];
   logic [21:0] m_sig[$];

   always #5 clk = ~clk;

   function automatic logic [21:0] net_hash(input logic [13:0] x);
      return {x[13:6], x} ^ {x[6:0], x, 1'b0} ^ 22'h12A5C3;
   endfunction

   function automatic logic [21:0] model_f(input logic [13:0] x);
      return (fsel == 0) ? fconst : net_hash(x);
   endfunction

   always_comb begin
      f1 = (fsel == 0) ? fconst : net_hash(x1);
      f3 = (fsel == 0) ? fconst : net_hash(x3);
   end

   always_comb begin
      o_x    = (sel == 3) ? x3    : x1;
      o_sig  = (sel == 3) ? sig3  : sig1;
      o_cnt  = (sel == 3) ? cnt3  : cnt1;
      o_busy = (sel == 3) ? busy3 : busy1;
      o_done = (sel == 3) ? done3 : done1;
      o_pass = (sel == 3) ? pass3 : pass1;
   end

   ccg_bist_sequencer #(.IN_W(14), .OUT_W(22), .SETTLE(1), .CNT_W(15)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .mode(mode), .seed(seed),
      .num_vectors(num_vectors), .exp_sig(exp_sig), .dut_x(x1), .dut_f(f1), .busy(busy1),
      .done(done1), .pass(pass1), .signature(sig1), .vec_count(cnt1));

   ccg_bist_sequencer #(.IN_W(14), .OUT_W(22), .SETTLE(3), .CNT_W(15)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .mode(mode), .seed(seed),
      .num_vectors(num_vectors), .exp_sig(exp_sig), .dut_x(x3), .dut_f(f3), .busy(busy3),
      .done(done3), .pass(pass3), .signature(sig3), .vec_count(cnt3));

   // Reference: vector k and signature after k captures, from the polynomial rules in plain integers.
   task automatic model_run(input logic md, input logic [13:0] sd, input int n);
      int v, s, f;
      m_vec.delete();
      m_sig.delete();
      v = md ? ((sd == 0) ? 1 : int'(sd)) : 0;
      s = 0;
      m_sig.push_back(22'(s));
      for (int k = 0; k < n; k++) begin
         m_vec.push_back(14'(v));
         f = int'(model_f(14'(v)));
         s = (((s << 1) | (((s >> 21) ^ (s >> 20)) & 1)) & 32'h3FFFFF) ^ f;
         if (md) v = ((v << 1) | (((v >> 13) ^ (v >> 4) ^ (v >> 2) ^ v) & 1)) & 32'h3FFF;
         else    v = (v + 1) % 16384;
         m_sig.push_back(22'(s));
      end
      m_vec.push_back(14'(v));
   endtask

   // Issues one start and records outputs every cycle up to one cycle past done (bounded).
   task automatic run_op(input int s_sel, input logic md, input logic [13:0] sd, input int n,
                         input logic [21:0] ex);
      int budget;
      sel    = s_sel;
      budget = n * s_sel + 10;
      @(negedge clk);
      mode = md; seed = sd; num_vectors = n[14:0]; exp_sig = ex;
      if (s_sel == 3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      mode = ~md; num_vectors = 15'($urandom); exp_sig = 22'($urandom);
      ob_x.delete(); ob_sig.delete(); ob_cnt.delete();
      ob_busy.delete(); ob_done.delete(); ob_pass.delete();
      done_cyc = -1;
      for (int k = 1; k <= budget; k++) begin
         ob_x.push_back(o_x);       ob_sig.push_back(o_sig);   ob_cnt.push_back(o_cnt);
         ob_busy.push_back(o_busy); ob_done.push_back(o_done); ob_pass.push_back(o_pass);
         if (o_done && done_cyc < 0) done_cyc = k;
         if (done_cyc >= 0 && k == done_cyc + 1) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2;
      n_total++; if (x1 !== 14'h0)    $display("FAIL reset_dut_x got %h want 0", x1);     else n_pass++;
      n_total++; if (sig1 !== 22'h0)  $display("FAIL reset_sig got %h want 0", sig1);     else n_pass++;
      n_total++; if (cnt1 !== 15'h0)  $display("FAIL reset_cnt got %0d want 0", cnt1);   else n_pass++;
      n_total++; if (busy1 !== 1'b0)  $display("FAIL reset_busy got %b want 0", busy1);   else n_pass++;
      n_total++; if (done1 !== 1'b0)  $display("FAIL reset_done got %b want 0", done1);   else n_pass++;
      n_total++; if (pass1 !== 1'b0)  $display("FAIL reset_pass got %b want 0", pass1);   else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_count_mode();
      fsel = 0; fconst = 22'h0;
      run_op(1, 1'b0, 14'($urandom), 4, 22'h0);
      for (int k = 1; k <= 4; k++) begin
         n_total++; if (ob_x[k-1] !== 14'(k-1)) $display("FAIL count_vec c%0d got %h want %h", k, ob_x[k-1], k-1); else n_pass++;
         n_total++; if (ob_busy[k-1] !== 1'b1)  $display("FAIL count_busy c%0d got %b want 1", k, ob_busy[k-1]); else n_pass++;
      end
      n_total++; if (done_cyc !== 5)          $display("FAIL count_done_cycle got %0d want 5", done_cyc); else n_pass++;
      n_total++; if (ob_sig[4] !== 22'h0)     $display("FAIL count_sig got %h want 0", ob_sig[4]);       else n_pass++;
      n_total++; if (ob_pass[4] !== 1'b1)     $display("FAIL count_pass got %b want 1", ob_pass[4]);     else n_pass++;
      n_total++; if (ob_cnt[4] !== 15'd4)     $display("FAIL count_vec_count got %0d want 4", ob_cnt[4]); else n_pass++;
      n_total++; if (ob_x[4] !== 14'd4)       $display("FAIL count_final_x got %h want 4", ob_x[4]);     else n_pass++;
      n_total++; if (ob_done[5] !== 1'b0)     $display("FAIL count_done_width got %b want 0", ob_done[5]); else n_pass++;
   endtask

   task automatic test_misr_const();
      fsel = 0; fconst = 22'h000001;
      run_op(1, 1'b0, 14'h0, 3, 22'h7);
      n_total++; if (ob_sig[1] !== 22'h1) $display("FAIL misr_step1 got %h want 1", ob_sig[1]); else n_pass++;
      n_total++; if (ob_sig[2] !== 22'h3) $display("FAIL misr_step2 got %h want 3", ob_sig[2]); else n_pass++;
      n_total++; if (ob_sig[3] !== 22'h7) $display("FAIL misr_final got %h want 7", ob_sig[3]); else n_pass++;
      n_total++; if (ob_pass[3] !== 1'b1) $display("FAIL misr_pass7 got %b want 1", ob_pass[3]); else n_pass++;
      n_total++; if (ob_pass[4] !== 1'b1) $display("FAIL misr_pass_hold got %b want 1", ob_pass[4]); else n_pass++;
      run_op(1, 1'b0, 14'h0, 3, 22'h6);
      n_total++; if (ob_pass[3] !== 1'b0) $display("FAIL misr_pass6 got %b want 0", ob_pass[3]); else n_pass++;
   endtask

   task automatic test_lfsr();
      logic [13:0] ref_v[3];
      ref_v[0] = 14'h0001; ref_v[1] = 14'h0003; ref_v[2] = 14'h0007;
      fsel = 1;
      for (int r = 0; r < 2; r++) begin
         run_op(1, 1'b1, (r == 0) ? 14'h0001 : 14'h0000, 3, 22'h0);
         for (int k = 0; k < 3; k++) begin
            n_total++; if (ob_x[k] !== ref_v[k]) $display("FAIL lfsr_vec seed%0d v%0d got %h want %h", 1 - r, k, ob_x[k], ref_v[k]); else n_pass++;
         end
      end
      model_run(1'b1, 14'h0, 3);
      n_total++; if (ob_sig[3] !== m_sig[3]) $display("FAIL lfsr_sig got %h want %h", ob_sig[3], m_sig[3]); else n_pass++;
   endtask

   task automatic test_settle();
      int nb;
      fsel = 1;
      model_run(1'b0, 14'h0, 2);
      run_op(3, 1'b0, 14'h0, 2, m_sig[2]);
      nb = 0;
      foreach (ob_busy[i]) if (ob_busy[i] === 1'b1) nb++;
      n_total++; if (nb !== 6)           $display("FAIL settle_busy_cycles got %0d want 6", nb); else n_pass++;
      n_total++; if (done_cyc !== 7)     $display("FAIL settle_done_cycle got %0d want 7", done_cyc); else n_pass++;
      n_total++; if (ob_cnt[6] !== 15'd2) $display("FAIL settle_vec_count got %0d want 2", ob_cnt[6]); else n_pass++;
      for (int k = 1; k <= 6; k++) begin
         n_total++; if (ob_x[k-1] !== 14'((k-1) / 3)) $display("FAIL settle_hold c%0d got %h want %h", k, ob_x[k-1], (k-1) / 3); else n_pass++;
      end
      n_total++; if (ob_pass[6] !== 1'b1) $display("FAIL settle_pass got %b want 1", ob_pass[6]); else n_pass++;
   endtask

   task automatic test_zero();
      int nb;
      fsel = 1;
      run_op(1, 1'($urandom), 14'($urandom), 0, 22'h0);
      nb = 0;
      foreach (ob_busy[i]) if (ob_busy[i] === 1'b1) nb++;
      n_total++; if (done_cyc !== 1)      $display("FAIL zero_done_cycle got %0d want 1", done_cyc); else n_pass++;
      n_total++; if (ob_sig[0] !== 22'h0) $display("FAIL zero_sig got %h want 0", ob_sig[0]); else n_pass++;
      n_total++; if (nb !== 0)            $display("FAIL zero_busy got %0d cycles want 0", nb); else n_pass++;
      n_total++; if (ob_pass[0] !== 1'b1) $display("FAIL zero_pass got %b want 1", ob_pass[0]); else n_pass++;
   endtask

   task automatic test_abort();
      logic saw;
      fsel = 1; sel = 1;
      model_run(1'b0, 14'h0, 10);
      @(negedge clk);
      mode = 1'b0; num_vectors = 15'd10; exp_sig = 22'h0; start1 = 1'b1;
      @(negedge clk);
      num_vectors = 15'd3;               // first APPLY cycle: this start must be ignored
      @(negedge clk);
      start1 = 1'b0; abort = 1'b1;       // second APPLY cycle
      @(negedge clk);
      abort = 1'b0;
      n_total++; if (busy1 !== 1'b0)     $display("FAIL abort_busy got %b want 0", busy1); else n_pass++;
      n_total++; if (cnt1 !== 15'd1)     $display("FAIL abort_vec_count got %0d want 1", cnt1); else n_pass++;
      n_total++; if (sig1 !== m_sig[1])  $display("FAIL abort_sig got %h want %h", sig1, m_sig[1]); else n_pass++;
      n_total++; if (pass1 !== 1'b0)     $display("FAIL abort_pass got %b want 0", pass1); else n_pass++;
      saw = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (done1 === 1'b1 || busy1 === 1'b1) saw = 1'b1;
         @(negedge clk);
      end
      n_total++; if (saw !== 1'b0) $display("FAIL abort_no_done got activity %b want 0", saw); else n_pass++;
      start1 = 1'b1; abort = 1'b1; num_vectors = 15'd5;
      @(negedge clk);
      start1 = 1'b0; abort = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (done1 === 1'b1 || busy1 === 1'b1) saw = 1'b1;
         @(negedge clk);
      end
      n_total++; if (saw !== 1'b0)   $display("FAIL abort_start_dropped got activity %b want 0", saw); else n_pass++;
      n_total++; if (cnt1 !== 15'd1) $display("FAIL abort_start_cnt got %0d want 1", cnt1); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic saw;
      fsel = 1; sel = 1;
      @(negedge clk);
      mode = 1'b1; seed = 14'($urandom); num_vectors = 15'd20; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      n_total++; if (busy1 !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy1); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (x1 !== 14'h0)   $display("FAIL rstmid_dut_x got %h want 0", x1); else n_pass++;
      n_total++; if (sig1 !== 22'h0) $display("FAIL rstmid_sig got %h want 0", sig1); else n_pass++;
      n_total++; if (cnt1 !== 15'h0) $display("FAIL rstmid_cnt got %0d want 0", cnt1); else n_pass++;
      n_total++; if (busy1 !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy1); else n_pass++;
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done1 === 1'b1) saw = 1'b1;
      end
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (done1 === 1'b1 || busy1 === 1'b1) saw = 1'b1;
      end
      n_total++; if (saw !== 1'b0) $display("FAIL rstmid_no_done got activity %b want 0", saw); else n_pass++;
   endtask

   task automatic test_random();
      int s_sel, n, d;
      logic md;
      logic [13:0] sd;
      logic [21:0] ex;
      fsel = 1;
      for (int it = 0; it < 10; it++) begin
         s_sel = ($urandom_range(0, 1) == 1) ? 3 : 1;
         md    = 1'($urandom);
         sd    = 14'($urandom);
         n     = $urandom_range(1, 40);
         model_run(md, sd, n);
         ex    = ($urandom_range(0, 1) == 1) ? m_sig[n] : (m_sig[n] ^ 22'(1 << $urandom_range(0, 21)));
         run_op(s_sel, md, sd, n, ex);
         d = n * s_sel;
         for (int k = 1; k <= d; k++) begin
            n_total++; if (ob_x[k-1] !== m_vec[(k-1) / s_sel]) $display("FAIL rand%0d_vec c%0d got %h want %h", it, k, ob_x[k-1], m_vec[(k-1) / s_sel]); else n_pass++;
            n_total++; if (ob_sig[k-1] !== m_sig[(k-1) / s_sel]) $display("FAIL rand%0d_sig c%0d got %h want %h", it, k, ob_sig[k-1], m_sig[(k-1) / s_sel]); else n_pass++;
            n_total++; if (ob_cnt[k-1] !== 15'((k-1) / s_sel)) $display("FAIL rand%0d_cnt c%0d got %0d want %0d", it, k, ob_cnt[k-1], (k-1) / s_sel); else n_pass++;
            n_total++; if (ob_busy[k-1] !== 1'b1) $display("FAIL rand%0d_busy c%0d got %b want 1", it, k, ob_busy[k-1]); else n_pass++;
         end
         n_total++; if (done_cyc !== d + 1) $display("FAIL rand%0d_done_cycle got %0d want %0d", it, done_cyc, d + 1); else n_pass++;
         n_total++; if (ob_sig[d] !== m_sig[n]) $display("FAIL rand%0d_final_sig got %h want %h", it, ob_sig[d], m_sig[n]); else n_pass++;
         n_total++; if (ob_pass[d] !== (ex == m_sig[n])) $display("FAIL rand%0d_pass got %b want %b", it, ob_pass[d], ex == m_sig[n]); else n_pass++;
         n_total++; if (ob_x[d] !== m_vec[n]) $display("FAIL rand%0d_final_x got %h want %h", it, ob_x[d], m_vec[n]); else n_pass++;
         n_total++; if (ob_busy[d] !== 1'b0) $display("FAIL rand%0d_busy_at_done got %b want 0", it, ob_busy[d]); else n_pass++;
         n_total++; if (ob_done[d+1] !== 1'b0) $display("FAIL rand%0d_done_pulse got %b want 0", it, ob_done[d+1]); else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int n;
      fsel = 1;
      n = 16390;
      model_run(1'b0, 14'h0, n);
      run_op(1, 1'b0, 14'h0, n, m_sig[n]);
      n_total++; if (done_cyc !== n + 1)      $display("FAIL wrap_done_cycle got %0d want %0d", done_cyc, n + 1); else n_pass++;
      n_total++; if (ob_x[16384] !== 14'h0)   $display("FAIL wrap_rollover got %h want 0", ob_x[16384]); else n_pass++;
      n_total++; if (ob_x[n] !== 14'd6)       $display("FAIL wrap_final_x got %h want 6", ob_x[n]); else n_pass++;
      n_total++; if (ob_sig[n] !== m_sig[n])  $display("FAIL wrap_sig got %h want %h", ob_sig[n], m_sig[n]); else n_pass++;
      n_total++; if (ob_pass[n] !== 1'b1)     $display("FAIL wrap_pass got %b want 1", ob_pass[n]); else n_pass++;
      n_total++; if (ob_cnt[n] !== 15'(n))    $display("FAIL wrap_cnt got %0d want %0d", ob_cnt[n], n); else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; mode = 1'b0;
      seed = '0; num_vectors = '0; exp_sig = '0;
      sel = 1; fsel = 0; fconst = '0;
      test_reset();
      test_count_mode();
      test_misr_const();
      test_lfsr();
      test_settle();
      test_zero();
      test_abort();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
